wb_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_load_queue.sv | 54 +++++
 rtl/wb_arbiter.sv | 117 +++++++++++
 tb/tb_wb_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants and the write-back entry type for the wb_arbiter slice.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_XLEN    = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus between the execute/load units, decode, and the register-file write port.
// slave: seen from the arbiter; master: seen from the units driving it.
import wb_pkg::*;

interface wb_arbiter_if #(
    parameter int XLEN = WB_XLEN
);
    logic                  stall;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [XLEN-1:0]       ex_data;
    logic                  ld_issue;
    logic [REG_ADDR_W-1:0] ld_issue_rd;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  rdWrite;
    logic [REG_ADDR_W-1:0] rdAddr;
    logic [XLEN-1:0]       rdData;
    logic [NUM_REGS-1:0]   busy_mask;

    modport slave (
        input  stall, ex_valid, ex_rd, ex_data, ld_issue, ld_issue_rd,
               ld_valid, ld_rd, ld_data,
        output ex_ready, ld_ready, rdWrite, rdAddr, rdData, busy_mask
    );

    modport master (
        output stall, ex_valid, ex_rd, ex_data, ld_issue, ld_issue_rd,
               ld_valid, ld_rd, ld_data,
        input  ex_ready, ld_ready, rdWrite, rdAddr, rdData, busy_mask
    );
endinterface

// File: rtl/wb_load_queue.sv
// Small FIFO holding returned load results until the write port is free.
// DEPTH must be a power of two so the pointers wrap naturally.
import wb_pkg::*;

module wb_load_queue #(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW:0]   count;
    wb_entry_t     mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[head_ptr];
    assign do_pop  = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // Entry storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail_ptr] <= push_entry;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + 1'b1;
            if (do_pop)  head_ptr <= head_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges execute results and queued load results onto the
// single register-file write port and tracks pending loads for decode.
// Optional macro WB_PERF_EN adds ex_block_cnt / ld_wr_cnt counters.
import wb_pkg::*;

module wb_arbiter #(
    parameter int XLEN     = WB_XLEN,
    parameter int LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_arbiter_if.slave       bus
`ifdef WB_PERF_EN
    ,
    output logic [31:0]       ex_block_cnt,
    output logic [31:0]       ld_wr_cnt
`endif
);
    logic                  full;
    logic                  empty;
    wb_entry_t             head;
    wb_entry_t             push_entry;
    logic                  push;
    logic                  pop;
    logic                  ex_take;
    logic [XLEN-1:0]       ld_data;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   clr_vec;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;

    assign ld_data       = bus.ld_data;
    assign push_entry    = '{rd: bus.ld_rd, data: ld_data};
    assign bus.ld_ready  = !full;
    assign push          = bus.ld_valid && !full;
    assign pop           = !bus.stall && !empty;
    // Loads always win: execute only proceeds when no load is queued or arriving.
    assign bus.ex_ready  = !bus.stall && empty && !push;
    assign ex_take       = bus.ex_valid && bus.ex_ready;

    assign bus.rdWrite   = wr_en;
    assign bus.rdAddr    = wr_addr;
    assign bus.rdData    = wr_data;
    assign bus.busy_mask = busy;

    wb_load_queue #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head       (head)
    );

    // Registered write port: queued load, else execute result, else idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (pop) begin
            wr_en   <= (head.rd != '0);
            wr_addr <= head.rd;
            wr_data <= head.data;
        end else if (ex_take) begin
            wr_en   <= (bus.ex_rd != '0);
            wr_addr <= bus.ex_rd;
            wr_data <= bus.ex_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Scoreboard set/clear vectors for this cycle.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (bus.ld_issue && bus.ld_issue_rd != '0) set_vec[bus.ld_issue_rd] = 1'b1;
        if (pop && head.rd != '0)                  clr_vec[head.rd]         = 1'b1;
    end

    // Pending-load scoreboard; a new issue overrides a same-cycle write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
        end
    end

`ifdef WB_PERF_EN
    // Blocked-execute and load-write counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_block_cnt <= '0;
            ld_wr_cnt    <= '0;
        end else begin
            if (bus.ex_valid && !bus.ex_ready) ex_block_cnt <= ex_block_cnt + 32'd1;
            if (pop && head.rd != '0)          ld_wr_cnt    <= ld_wr_cnt + 32'd1;
        end
    end
`endif

    // Reissuing a register on the cycle its previous load is written back is legal.
    a_issue_busy : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.ld_issue && bus.ld_issue_rd != '0 && busy[bus.ld_issue_rd] && !clr_vec[bus.ld_issue_rd]));
    a_ex_busy : assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_take && bus.ex_rd != '0 && busy[bus.ex_rd]));
    a_ld_not_busy : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.ld_valid && bus.ld_rd != '0 && !busy[bus.ld_rd]));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (default build, counters absent).
module tb_wb_arbiter;
    logic clk;
    logic rst_n;
    int unsigned total;
    int unsigned bad;

    wb_arbiter_if #(.XLEN(32)) bus ();

    wb_arbiter #(
        .XLEN     (32),
        .LQ_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [4:0] addr,
                            input logic [31:0] data);
        check_eq({tag, ".rdWrite"}, 64'(bus.rdWrite), 64'(en));
        check_eq({tag, ".rdAddr"},  64'(bus.rdAddr),  64'(addr));
        check_eq({tag, ".rdData"},  64'(bus.rdData),  64'(data));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_rd = '0; bus.ex_data = '0;
        bus.ld_issue = 1'b0; bus.ld_issue_rd = '0;
        bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;

        // Reset state
        #3;
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        check_eq("rst.busy", 64'(bus.busy_mask), 64'h0);
        check_eq("rst.ld_ready", 64'(bus.ld_ready), 64'h1);
        #19 rst_n = 1'b1;
        tick();

        // Execute only: one-cycle latency, write-data held when idle
        bus.ex_valid = 1'b1; bus.ex_rd = 5'd5; bus.ex_data = 32'hDEADBEEF;
        #1 check_eq("ex.ready", 64'(bus.ex_ready), 64'h1);
        tick();
        bus.ex_valid = 1'b0;
        check_wr("ex.wr", 1'b1, 5'd5, 32'hDEADBEEF);
        #1 check_eq("ex.ready_idle", 64'(bus.ex_ready), 64'h1);
        tick();
        check_wr("ex.hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // Load path
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd7;
        tick();
        bus.ld_issue = 1'b0;
        check_eq("ld.busy_set", 64'(bus.busy_mask), 64'h80);
        tick();
        tick();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h1234;
        tick();
        bus.ld_valid = 1'b0;
        check_eq("ld.wait_wr", 64'(bus.rdWrite), 64'h0);
        check_eq("ld.wait_busy", 64'(bus.busy_mask), 64'h80);
        check_eq("ld.ready_1", 64'(bus.ld_ready), 64'h1);
        tick();
        check_wr("ld.wr", 1'b1, 5'd7, 32'h1234);
        check_eq("ld.busy_clr", 64'(bus.busy_mask), 64'h0);

        // Contention: load beats execute
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd3;
        tick();
        bus.ld_issue = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'h33;
        bus.ex_valid = 1'b1; bus.ex_rd = 5'd4; bus.ex_data = 32'h44;
        #1 check_eq("ct.ex_ready_ld", 64'(bus.ex_ready), 64'h0);
        tick();
        bus.ld_valid = 1'b0;
        check_eq("ct.no_wr", 64'(bus.rdWrite), 64'h0);
        #1 check_eq("ct.ex_ready_q", 64'(bus.ex_ready), 64'h0);
        tick();
        check_wr("ct.ld_wr", 1'b1, 5'd3, 32'h33);
        #1 check_eq("ct.ex_ready_free", 64'(bus.ex_ready), 64'h1);
        tick();
        bus.ex_valid = 1'b0;
        check_wr("ct.ex_wr", 1'b1, 5'd4, 32'h44);
        check_eq("ct.busy", 64'(bus.busy_mask), 64'h0);

        // Stall with the queue filled
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd1;
        tick();
        bus.ld_issue_rd = 5'd2;
        tick();
        bus.ld_issue = 1'b0;
        bus.stall = 1'b1;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd1; bus.ld_data = 32'h11;
        tick();
        check_eq("st.wr0", 64'(bus.rdWrite), 64'h0);
        bus.ld_rd = 5'd2; bus.ld_data = 32'h22;
        tick();
        bus.ld_valid = 1'b0;
        #1;
        check_eq("st.ld_ready_full", 64'(bus.ld_ready), 64'h0);
        check_eq("st.wr1", 64'(bus.rdWrite), 64'h0);
        check_eq("st.ex_ready", 64'(bus.ex_ready), 64'h0);
        tick();
        check_eq("st.wr2", 64'(bus.rdWrite), 64'h0);
        check_eq("st.busy", 64'(bus.busy_mask), 64'h6);
        bus.stall = 1'b0;
        tick();
        check_wr("st.pop1", 1'b1, 5'd1, 32'h11);
        check_eq("st.ld_ready_back", 64'(bus.ld_ready), 64'h1);
        check_eq("st.busy1", 64'(bus.busy_mask), 64'h4);
        tick();
        check_wr("st.pop2", 1'b1, 5'd2, 32'h22);
        check_eq("st.busy2", 64'(bus.busy_mask), 64'h0);
        tick();
        check_eq("st.idle", 64'(bus.rdWrite), 64'h0);

        // Execute to x0: consumed, no write enable
        bus.ex_valid = 1'b1; bus.ex_rd = 5'd0; bus.ex_data = 32'hFF;
        #1 check_eq("x0.ex_ready", 64'(bus.ex_ready), 64'h1);
        tick();
        bus.ex_valid = 1'b0;
        check_wr("x0.wr", 1'b0, 5'd0, 32'hFF);

        // Set/clear collision on r9: set wins
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd9;
        tick();
        bus.ld_issue = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h99;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd9;
        tick();
        check_wr("col.wr", 1'b1, 5'd9, 32'h99);
        check_eq("col.busy", 64'(bus.busy_mask), 64'h200);

        // Async reset mid-cycle with a load still queued
        bus.ld_issue_rd = 5'd10;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'hAA;
        tick();
        bus.ld_issue = 1'b0;
        bus.ld_rd = 5'd10; bus.ld_data = 32'hBB;
        tick();
        bus.ld_valid = 1'b0;
        check_wr("ar.pre", 1'b1, 5'd9, 32'hAA);
        check_eq("ar.pre_busy", 64'(bus.busy_mask), 64'h400);
        #2 rst_n = 1'b0;
        #1;
        check_wr("ar.now", 1'b0, 5'd0, 32'h0);
        check_eq("ar.busy", 64'(bus.busy_mask), 64'h0);
        check_eq("ar.ld_ready", 64'(bus.ld_ready), 64'h1);
        #4 rst_n = 1'b1;
        tick();
        check_eq("ar.dropped", 64'(bus.rdWrite), 64'h0);
        tick();
        check_eq("ar.dropped2", 64'(bus.rdWrite), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
